mem_stage: RTL and testbench

// Memory-access stage plus MEM/WB pipeline register of the 5-stage RV32I core. Consumes the
// EX/MEM register outputs, performs loads/stores over a ready-handshake data-memory port,

---
 rtl/mem_stage_if.sv | 31 +++
 rtl/mem_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/response port of the MEM stage.
// master = pipeline side, slave = memory side.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_wstrb,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_wstrb,
    output dmem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage with MEM/WB register.
// Handshaked data-memory access, load extension, stall/fault.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AluResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] pc_plus_fourM,
  input  logic [4:0]  RdM,
  mem_stage_if.master dmem,
  output logic        stall_mem,
  output logic        mem_fault,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] AluResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] pc_plus_fourW,
  output logic [4:0]  RdW
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } mem_wb_t;

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAST =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;

  logic       is_store;
  logic       is_load;
  logic       mem_op;
  logic       is_b;
  logic       is_h;
  logic       is_w;
  logic       f3_ok;
  logic       aligned;
  logic       legal;
  logic       bad_op;
  logic [1:0] off;
  logic       busy;
  logic       done;
  logic       tmo;

  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [31:0] rsh;
  logic [15:0] lh;
  logic [31:0] load_data;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  mem_wb_t wb_d;
  mem_wb_t wb_q;

  // A store flag overrides a load-select result source.
  assign is_store = MemWriteM;
  assign is_load  = ~MemWriteM & (ResultSrcM == 2'b01);
  assign mem_op   = is_store | is_load;
  assign off      = AluResultM[1:0];

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    unique case (Funct3M[1:0])
      2'b00:   is_b = 1'b1;
      2'b01:   is_h = 1'b1;
      2'b10:   is_w = 1'b1;
      default: ;
    endcase
  end

  assign f3_ok = is_store
    ? ~Funct3M[2] & (is_b | is_h | is_w)
    : (is_b | is_h) | (is_w & ~Funct3M[2]);

  assign aligned = is_b
    | (is_h & ~off[0])
    | (is_w & (off == 2'b00));

  assign legal  = mem_op & f3_ok & aligned;
  assign bad_op = mem_op & ~legal;

  assign busy = (state_q == BUSY);
  assign done = busy & dmem.dmem_ready;
  assign tmo  = TMO_EN & busy & ~dmem.dmem_ready
              & (cnt_q == CNT_LAST);

  assign stall_mem = reset & legal & ~done & ~tmo;
  assign mem_fault = reset & (bad_op | tmo);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (legal) state_d = BUSY;
      BUSY: if (done | tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (busy & ~done & ~tmo) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  always_comb begin
    strb_n  = 4'b1111;
    wdata_n = WriteDataM;
    unique case (1'b1)
      is_b: begin
        strb_n  = 4'b0001 << off;
        wdata_n = {4{WriteDataM[7:0]}};
      end
      is_h: begin
        strb_n  = 4'b0011 << {off[1], 1'b0};
        wdata_n = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  // Request fields are frozen for the whole BUSY window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (!busy && legal) begin
      we_q    <= is_store;
      addr_q  <= {AluResultM[31:2], 2'b00};
      wdata_q <= is_store ? wdata_n : 32'd0;
      wstrb_q <= is_store ? strb_n : 4'b0000;
    end else if (done | tmo) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end
  end

  assign dmem.dmem_req   = busy;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;

  assign rsh = dmem.dmem_rdata >> {off, 3'b000};
  assign lh  = off[1] ? dmem.dmem_rdata[31:16]
                      : dmem.dmem_rdata[15:0];

  always_comb begin
    load_data = dmem.dmem_rdata;
    unique case (1'b1)
      is_b: load_data =
        {{24{~Funct3M[2] & rsh[7]}}, rsh[7:0]};
      is_h: load_data =
        {{16{~Funct3M[2] & lh[15]}}, lh};
      default: ;
    endcase
  end

  // Stall and fault cycles both push a bubble.
  always_comb begin
    wb_d = '0;
    if (!stall_mem && !mem_fault) begin
      wb_d.rw    = RegWriteM & ~is_store;
      wb_d.rs    = ResultSrcM;
      wb_d.alu   = AluResultM;
      wb_d.rdata = is_load ? load_data : 32'd0;
      wb_d.pc4   = pc_plus_fourM;
      wb_d.rd    = RdM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign RegWriteW     = wb_q.rw;
  assign ResultSrcW    = wb_q.rs;
  assign AluResultW    = wb_q.alu;
  assign ReadDataW     = wb_q.rdata;
  assign pc_plus_fourW = wb_q.pc4;
  assign RdW           = wb_q.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage.
// Directed ops; monitor pops expected MEM/WB records.
module tb_mem_stage;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdat;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] AluResultM;
  logic [31:0] WriteDataM;
  logic [31:0] pc_plus_fourM;
  logic [4:0]  RdM;
  logic        stall_mem;
  logic        mem_fault;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] AluResultW;
  logic [31:0] ReadDataW;
  logic [31:0] pc_plus_fourW;
  logic [4:0]  RdW;

  mem_stage_if dmem();

  mem_stage #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk),
    .reset(reset),
    .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M),
    .AluResultM(AluResultM),
    .WriteDataM(WriteDataM),
    .pc_plus_fourM(pc_plus_fourM),
    .RdM(RdM),
    .dmem(dmem.master),
    .stall_mem(stall_mem),
    .mem_fault(mem_fault),
    .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW),
    .AluResultW(AluResultW),
    .ReadDataW(ReadDataW),
    .pc_plus_fourW(pc_plus_fourW),
    .RdW(RdW)
  );

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  wb_t exp_q[$];

  int          mem_delay = 0;
  bit          mem_never = 1'b1;
  logic [31:0] mem_data  = '0;
  int          busy_n    = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, expv);
    end
  endtask

  function automatic wb_t mk(input logic rw,
                             input logic [1:0] rs,
                             input logic [31:0] alu,
                             input logic [31:0] rdat,
                             input logic [31:0] pc4,
                             input logic [4:0] rd);
    wb_t e;
    e.rw = rw; e.rs = rs; e.alu = alu;
    e.rdat = rdat; e.pc4 = pc4; e.rd = rd;
    return e;
  endfunction

  // Memory model: ready on the mem_delay-th request cycle.
  initial begin
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = 32'h5555_5555;
    forever begin
      @(posedge clk);
      #1;
      if (dmem.dmem_req) busy_n++;
      else busy_n = 0;
      dmem.dmem_ready = dmem.dmem_req && !mem_never
                        && (busy_n == mem_delay);
      dmem.dmem_rdata = dmem.dmem_ready ? mem_data
                                        : 32'h5555_5555;
    end
  end

  // Any non-bubble MEM/WB content must match the next record.
  always @(negedge clk) begin
    wb_t e;
    if (reset === 1'b1 &&
        (RegWriteW || ResultSrcW != 0 || AluResultW != 0 ||
         ReadDataW != 0 || pc_plus_fourW != 0 || RdW != 0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d alu=0x%08h expected bubble",
                 RdW, AluResultW);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rw", {31'd0, RegWriteW}, {31'd0, e.rw});
        chk("wb_rs", {30'd0, ResultSrcW}, {30'd0, e.rs});
        chk("wb_alu", AluResultW, e.alu);
        chk("wb_rdata", ReadDataW, e.rdat);
        chk("wb_pc4", pc_plus_fourW, e.pc4);
        chk("wb_rd", {27'd0, RdW}, {27'd0, e.rd});
      end
    end
  end

  task automatic nop_in();
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0;
    Funct3M = 0; AluResultM = 0; WriteDataM = 0;
    pc_plus_fourM = 0; RdM = 0;
  endtask

  // Called just after a rising edge; returns just after one.
  task automatic op(input string nm,
                    input logic rw, input logic mw,
                    input logic [1:0] rs, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] pc4, input logic [4:0] rd,
                    input int dly, input logic [31:0] rdat,
                    input bit push, input wb_t e,
                    input int x_stall, input int x_fault,
                    input int x_req, input logic [3:0] x_strb,
                    input logic [31:0] x_wdata, input logic x_we);
    int          stalls = 0;
    int          faults = 0;
    int          reqs = 0;
    bit          fin = 0;
    bit          unstable = 0;
    logic [3:0]  strb = '0;
    logic [31:0] wdat = '0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    mem_delay = dly;
    mem_never = (dly == 0);
    mem_data  = rdat;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
    Funct3M = f3; AluResultM = a; WriteDataM = wd;
    pc_plus_fourM = pc4; RdM = rd;
    if (push) exp_q.push_back(e);
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      if (stall_mem) stalls++;
      if (mem_fault) faults++;
      if (dmem.dmem_req) begin
        if (reqs > 0 &&
            (strb != dmem.dmem_wstrb || wdat != dmem.dmem_wdata ||
             addr != dmem.dmem_addr || we != dmem.dmem_we))
          unstable = 1;
        strb = dmem.dmem_wstrb; wdat = dmem.dmem_wdata;
        addr = dmem.dmem_addr;  we = dmem.dmem_we;
        reqs++;
      end
      if (!stall_mem) fin = 1;
      @(posedge clk);
      #1;
    end
    nop_in();
    chk({nm, " released"}, {31'd0, fin}, 32'd1);
    chk({nm, " stall_cycles"}, stalls, x_stall);
    chk({nm, " fault_cycles"}, faults, x_fault);
    chk({nm, " req_cycles"}, reqs, x_req);
    if (x_req > 0) begin
      chk({nm, " addr"}, addr, {a[31:2], 2'b00});
      chk({nm, " wstrb"}, {28'd0, strb}, {28'd0, x_strb});
      chk({nm, " wdata"}, wdat, x_wdata);
      chk({nm, " we"}, {31'd0, we}, {31'd0, x_we});
      chk({nm, " req_stable"}, {31'd0, unstable}, 32'd0);
    end
    @(negedge clk);
    chk({nm, " req_after"}, {31'd0, dmem.dmem_req}, 32'd0);
    if (!push) begin
      chk({nm, " bubble_rw"}, {31'd0, RegWriteW}, 32'd0);
      chk({nm, " bubble_rd"}, {27'd0, RdW}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, " req"}, {31'd0, dmem.dmem_req}, 32'd0);
    chk({nm, " stall"}, {31'd0, stall_mem}, 32'd0);
    chk({nm, " fault"}, {31'd0, mem_fault}, 32'd0);
    chk({nm, " rw"}, {31'd0, RegWriteW}, 32'd0);
    chk({nm, " rs"}, {30'd0, ResultSrcW}, 32'd0);
    chk({nm, " alu"}, AluResultW, 32'd0);
    chk({nm, " rdata"}, ReadDataW, 32'd0);
    chk({nm, " pc4"}, pc_plus_fourW, 32'd0);
    chk({nm, " rd"}, {27'd0, RdW}, 32'd0);
    chk({nm, " wstrb"}, {28'd0, dmem.dmem_wstrb}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  wb_t z;

  initial begin
    z = '0;
    reset = 1'b0;
    nop_in();
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    op("alu", 1, 0, 2'b00, 3'b000, 32'h1234, 0, 32'h44, 5,
       0, 0, 1, mk(1, 2'b00, 32'h1234, 0, 32'h44, 5),
       0, 0, 0, 4'b0000, 0, 0);
    op("lb", 1, 0, 2'b01, 3'b000, 32'h103, 0, 32'h48, 7,
       1, 32'h80FF_0000, 1,
       mk(1, 2'b01, 32'h103, 32'hFFFF_FF80, 32'h48, 7),
       1, 0, 1, 4'b0000, 0, 0);
    op("sh", 1, 1, 2'b00, 3'b001, 32'h202, 32'hABCD, 32'h4C, 9,
       4, 0, 1, mk(0, 2'b00, 32'h202, 0, 32'h4C, 9),
       4, 0, 4, 4'b1100, 32'hABCD_ABCD, 1);
    op("lw_mis", 1, 0, 2'b01, 3'b010, 32'h101, 0, 32'h50, 10,
       0, 0, 0, z, 0, 1, 0, 4'b0000, 0, 0);
    op("lbu", 1, 0, 2'b01, 3'b100, 32'h101, 0, 32'h54, 11,
       2, 32'h1234_80AB, 1,
       mk(1, 2'b01, 32'h101, 32'h0000_0080, 32'h54, 11),
       2, 0, 2, 4'b0000, 0, 0);
    op("lh", 1, 0, 2'b01, 3'b001, 32'h102, 0, 32'h58, 12,
       1, 32'h8001_0000, 1,
       mk(1, 2'b01, 32'h102, 32'hFFFF_8001, 32'h58, 12),
       1, 0, 1, 4'b0000, 0, 0);
    op("lhu", 1, 0, 2'b01, 3'b101, 32'h100, 0, 32'h5C, 13,
       3, 32'h0000_F00D, 1,
       mk(1, 2'b01, 32'h100, 32'h0000_F00D, 32'h5C, 13),
       3, 0, 3, 4'b0000, 0, 0);
    op("lw", 1, 0, 2'b01, 3'b010, 32'h104, 0, 32'h60, 14,
       1, 32'hDEAD_BEEF, 1,
       mk(1, 2'b01, 32'h104, 32'hDEAD_BEEF, 32'h60, 14),
       1, 0, 1, 4'b0000, 0, 0);
    op("sb", 1, 1, 2'b00, 3'b000, 32'h105, 32'h1234_565A,
       32'h64, 15, 2, 0, 1,
       mk(0, 2'b00, 32'h105, 0, 32'h64, 15),
       2, 0, 2, 4'b0010, 32'h5A5A_5A5A, 1);
    op("sw", 0, 1, 2'b00, 3'b010, 32'h108, 32'hCAFE_F00D,
       32'h68, 0, 1, 0, 1,
       mk(0, 2'b00, 32'h108, 0, 32'h68, 0),
       1, 0, 1, 4'b1111, 32'hCAFE_F00D, 1);
    op("link", 1, 0, 2'b10, 3'b000, 32'h2000, 0, 32'h6C, 1,
       0, 0, 1, mk(1, 2'b10, 32'h2000, 0, 32'h6C, 1),
       0, 0, 0, 4'b0000, 0, 0);
    op("st_f3", 0, 1, 2'b00, 3'b100, 32'h200, 32'h77, 32'h70, 2,
       0, 0, 0, z, 0, 1, 0, 4'b0000, 0, 0);
    op("ld_f3", 1, 0, 2'b01, 3'b011, 32'h200, 0, 32'h74, 2,
       0, 0, 0, z, 0, 1, 0, 4'b0000, 0, 0);
    op("lhu_mis", 1, 0, 2'b01, 3'b101, 32'h103, 0, 32'h78, 4,
       0, 0, 0, z, 0, 1, 0, 4'b0000, 0, 0);
    op("st_and_ld", 1, 1, 2'b01, 3'b010, 32'h10C, 32'h1111_2222,
       32'h7C, 3, 1, 32'h9999_9999, 1,
       mk(0, 2'b01, 32'h10C, 0, 32'h7C, 3),
       1, 0, 1, 4'b1111, 32'h1111_2222, 1);
    op("timeout", 1, 0, 2'b01, 3'b010, 32'h300, 0, 32'h80, 6,
       0, 0, 0, z, 15, 1, 15, 4'b0000, 0, 0);

    // Reset while BUSY waiting on a memory that never answers.
    mem_never = 1'b1;
    RegWriteM = 1; ResultSrcM = 2'b01; Funct3M = 3'b010;
    AluResultM = 32'h400; pc_plus_fourM = 32'h84; RdM = 8;
    repeat (3) @(negedge clk);
    chk("pre_reset req", {31'd0, dmem.dmem_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_quiet("reset_busy");
    nop_in();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("post_reset stall", {31'd0, stall_mem}, 32'd0);
    @(posedge clk);
    #1;
    op("alu2", 1, 0, 2'b00, 3'b000, 32'h55AA, 0, 32'h88, 20,
       0, 0, 1, mk(1, 2'b00, 32'h55AA, 0, 32'h88, 20),
       0, 0, 0, 4'b0000, 0, 0);
    op("lb_after", 1, 0, 2'b01, 3'b000, 32'h500, 0, 32'h8C, 21,
       1, 32'h0000_007F, 1,
       mk(1, 2'b01, 32'h500, 32'h0000_007F, 32'h8C, 21),
       1, 0, 1, 4'b0000, 0, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
